// File: rtl/cic_pkg.sv
// Shared CIC constants and the bit-growth rule.
// The defaults match the integrator chain so both halves of the filter agree.
package cic_pkg;

  localparam int CIC_WIDTH  = 16;
  localparam int CIC_STAGES = 3;
  localparam int CIC_DECIM  = 8;
  localparam int CIC_DELAY  = 1;

  // Minimum register width for a CIC with in_bits input bits, n stages,
  // decimation r and differential delay m.
  function automatic int cic_width(input int in_bits, input int n, input int r, input int m);
    return in_bits + n * $clog2(r * m);
  endfunction

  // Width of the decimation phase counter; never zero, even when r is 1.
  function automatic int cic_cnt_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/comb_stage.sv
// One CIC comb (differentiator) section: dout = din - din[n-DELAY].
// REGISTERED=1 puts a flop on the difference and the valid strobe;
// REGISTERED=0 leaves the stage purely combinational apart from its delay line.
module comb_stage #(
  parameter int WIDTH      = 16,
  parameter int DELAY      = 1,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dline [DELAY];
  logic [WIDTH-1:0] diff;

  // Modulo-2^WIDTH subtraction cancels the integrator wrap.
  assign diff = din - dline[DELAY-1];

  // Delay line of past inputs; it only shifts on a valid sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the delay line is small and must start from zero after reset so
      // the first outputs are exact, hence it is a reset flop array, not a RAM.
      for (int i = 0; i < DELAY; i++) dline[i] <= '0;
    end else if (in_valid) begin
      dline[0] <= din;
      for (int i = 1; i < DELAY; i++) dline[i] <= dline[i-1];
    end
  end

  if (REGISTERED) begin : g_reg
    // Registered difference and its valid flop; dout holds between samples.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        out_valid <= 1'b0;
        dout      <= '0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) dout <= diff;
      end
    end
  end else begin : g_comb
    assign out_valid = in_valid;
    assign dout      = diff;
  end

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC comb-and-decimate back end: keeps one in DECIM valid integrator samples
// and differentiates it through STAGES comb sections of delay DELAY.
// Build option CIC_COMB_PIPELINE_EN: register every comb stage (latency
// STAGES); otherwise the comb chain is combinational into one output register
// (latency 1). Both builds give the same y sequence.
module cic_comb_decimator
  import cic_pkg::*;
#(
  parameter int WIDTH  = CIC_WIDTH,
  parameter int STAGES = CIC_STAGES,
  parameter int DECIM  = CIC_DECIM,
  parameter int DELAY  = CIC_DELAY
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
);

  localparam int PW = cic_cnt_width(DECIM);
`ifdef CIC_COMB_PIPELINE_EN
  localparam bit REGISTERED = 1'b1;
`else
  localparam bit REGISTERED = 1'b0;
`endif

  // Elaboration-time parameter checks.
  if (STAGES < 1) begin : g_bad_stages
    $error("cic_comb_decimator: STAGES must be >= 1");
  end
  if (DECIM < 1) begin : g_bad_decim
    $error("cic_comb_decimator: DECIM must be >= 1");
  end
  if (DELAY < 1) begin : g_bad_delay
    $error("cic_comb_decimator: DELAY must be >= 1");
  end
  if (WIDTH < cic_width(1, STAGES, DECIM, DELAY)) begin : g_bad_width
    $error("cic_comb_decimator: WIDTH too small for the CIC bit growth");
  end

  logic [PW-1:0] phase;
  logic          accept;

  assign accept = in_valid && (phase == PW'(DECIM - 1));

  // Phase counter: counts valid samples only, wrapping at DECIM-1.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers take non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    if (!rstn)                          phase <= '0;
    else if (in_valid && accept)        phase <= '0;
    else if (in_valid)                  phase <= phase + PW'(1);
  end

  // Comb chain: stage 0 is fed by the accepted sample, later stages by their
  // predecessor.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vin;
    logic             vout;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    if (k == 0) begin : g_first
      assign vin = accept;
      assign din = x;
    end else begin : g_next
      assign vin = g_stage[k-1].vout;
      assign din = g_stage[k-1].dout;
    end

    comb_stage #(
      .WIDTH      (WIDTH),
      .DELAY      (DELAY),
      .REGISTERED (REGISTERED)
    ) u_comb (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (vin),
      .din       (din),
      .out_valid (vout),
      .dout      (dout)
    );
  end

`ifdef CIC_COMB_PIPELINE_EN
  // The last registered stage is the output register.
  assign out_valid = g_stage[STAGES-1].vout;
  assign y         = g_stage[STAGES-1].dout;
`else
  // Single output register after the combinational comb chain; y holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      out_valid <= g_stage[STAGES-1].vout;
      if (g_stage[STAGES-1].vout) y <= g_stage[STAGES-1].dout;
    end
  end
`endif

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Directed bench for cic_comb_decimator. Four instances cover reset and
// default decimation, gapped decimation, a single-stage table of step and
// wrap vectors, and a full N=3/R=4 CIC fed by bench-side integrators.
module tb_cic_comb_decimator;

`ifdef CIC_COMB_PIPELINE_EN
  localparam int LAT3 = 3;
`else
  localparam int LAT3 = 1;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic a_v = 1'b0, b_v = 1'b0, c_v = 1'b0, d_v = 1'b0;
  logic [15:0] a_x = '0, b_x = '0, c_x = '0, d_x = '0;
  logic a_ov, b_ov, c_ov, d_ov;
  logic [15:0] a_y, b_y, c_y, d_y;

  // Defaults: WIDTH 16, STAGES 3, DECIM 8, DELAY 1.
  cic_comb_decimator u_a (
    .clk(clk), .rstn(rstn), .in_valid(a_v), .x(a_x), .out_valid(a_ov), .y(a_y));

  cic_comb_decimator #(.WIDTH(16), .STAGES(1), .DECIM(4), .DELAY(1)) u_b (
    .clk(clk), .rstn(rstn), .in_valid(b_v), .x(b_x), .out_valid(b_ov), .y(b_y));

  cic_comb_decimator #(.WIDTH(16), .STAGES(1), .DECIM(1), .DELAY(1)) u_c (
    .clk(clk), .rstn(rstn), .in_valid(c_v), .x(c_x), .out_valid(c_ov), .y(c_y));

  cic_comb_decimator #(.WIDTH(16), .STAGES(3), .DECIM(4), .DELAY(1)) u_d (
    .clk(clk), .rstn(rstn), .in_valid(d_v), .x(d_x), .out_valid(d_ov), .y(d_y));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-stage, DECIM=1 vectors: y is x minus the previous valid x.
  typedef struct {
    logic        v;
    logic [15:0] x;
    logic        ov;
    logic [15:0] y;
  } vec_t;
  localparam int NV = 11;
  vec_t tbl [NV];

  // Full-CIC model state: integrators, accept history, pulse count.
  logic [15:0] i1, i2, i3;
  logic [7:0]  sr;
  int          s_cnt;
  int          pc;

  task automatic cic_model_reset();
    i1 = '0; i2 = '0; i3 = '0; sr = '0; s_cnt = 0; pc = 0;
  endtask

  // One cycle of the full CIC: check the outputs, then drive the next sample.
  // Steady-state y is (R*M)^N = 64; from zeroed delay lines the first two
  // pulses are 20 and 60 (x = 20, 120, 364, ... at the accepted samples).
  task automatic cic_step(input bit drive);
    logic [15:0] exp_y;
    @(negedge clk);
    sr = sr << 1;
    check("d_out_valid", {31'd0, d_ov}, {31'd0, sr[LAT3]});
    if (sr[LAT3]) begin
      exp_y = (pc == 0) ? 16'd20 : ((pc == 1) ? 16'd60 : 16'd64);
      check("d_y", {16'd0, d_y}, {16'd0, exp_y});
      pc++;
    end
    if (drive) begin
      i1 = i1 + 16'd1;
      i2 = i2 + i1;
      i3 = i3 + i2;
      d_v = 1'b1;
      d_x = i3;
      sr[0] = (s_cnt % 4 == 3);
      s_cnt++;
    end else begin
      d_v = 1'b0;
    end
  endtask

  initial begin
    logic        pend;
    logic [15:0] pend_y;
    logic [15:0] last_acc;
    int          nvalid;

    tbl[0]  = '{1'b1, 16'h0005, 1'b1, 16'h0005};
    tbl[1]  = '{1'b1, 16'h0005, 1'b1, 16'h0000};
    tbl[2]  = '{1'b1, 16'h0005, 1'b1, 16'h0000};
    tbl[3]  = '{1'b0, 16'h1234, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 16'h0000, 1'b1, 16'hFFFB};
    tbl[5]  = '{1'b1, 16'h0000, 1'b1, 16'h0000};
    tbl[6]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF};
    tbl[7]  = '{1'b1, 16'h0001, 1'b1, 16'h0002};
    tbl[8]  = '{1'b0, 16'h7777, 1'b0, 16'h0002};
    tbl[9]  = '{1'b1, 16'h8000, 1'b1, 16'h7FFF};
    tbl[10] = '{1'b1, 16'h8000, 1'b1, 16'h0000};

    // Reset held with in_valid toggling: outputs stay zero, no pulses.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_a_out_valid", {31'd0, a_ov}, 32'd0);
      check("rst_a_y", {16'd0, a_y}, 32'd0);
      a_v = ~a_v;
      a_x = 16'h1234;
    end
    @(negedge clk);
    rstn = 1'b1;
    a_v  = 1'b0;

    // Seven valid inputs at DECIM=8 give no pulse; the eighth is accepted.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("a_no_pulse", {31'd0, a_ov}, 32'd0);
      a_v = 1'b1;
      a_x = 16'h0100 + 16'(i);
    end
    for (int k = 1; k <= LAT3 + 1; k++) begin
      @(negedge clk);
      a_v = 1'b0;
      check("a_latency", {31'd0, a_ov}, {31'd0, k == LAT3});
      if (k == LAT3) check("a_first_y", {16'd0, a_y}, 32'h0107);
    end

    // DECIM=4 with in_valid 1-0-1...: pulses on valid samples 3, 7, 11.
    pend = 1'b0; pend_y = '0; last_acc = '0; nvalid = 0;
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      check("b_out_valid", {31'd0, b_ov}, {31'd0, pend});
      if (pend) check("b_y", {16'd0, b_y}, {16'd0, pend_y});
      if (c % 2 == 0 && c < 30) begin
        b_v = 1'b1;
        b_x = 16'(nvalid);
        pend = (nvalid % 4 == 3);
        if (pend) begin
          pend_y   = 16'(nvalid) - last_acc;
          last_acc = 16'(nvalid);
        end
        nvalid++;
      end else begin
        b_v  = 1'b0;
        pend = 1'b0;
      end
    end

    // Step and wrap-around vectors, single stage, DECIM=1.
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("c_out_valid", {31'd0, c_ov}, {31'd0, tbl[i-1].ov});
        check("c_y", {16'd0, c_y}, {16'd0, tbl[i-1].y});
      end
      if (i < NV) begin
        c_v = tbl[i].v;
        c_x = tbl[i].x;
      end else begin
        c_v = 1'b0;
      end
    end

    // Full CIC from constant 1 through three 16-bit integrators; runs past
    // integrator wrap. Sample 99 is accepted on the last step.
    cic_model_reset();
    repeat (100) cic_step(1'b1);
    cic_step(1'b1);
    // Reset while sample 99 is still in the pipeline.
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_out_valid", {31'd0, d_ov}, 32'd0);
      check("mid_rst_y", {16'd0, d_y}, 32'd0);
      d_v = ~d_v;
      d_x = 16'hBEEF;
    end
    @(negedge clk);
    rstn = 1'b1;
    d_v  = 1'b0;
    // Fresh start: first pulse after four new samples, delay lines from zero.
    cic_model_reset();
    repeat (30) cic_step(1'b1);
    repeat (4)  cic_step(1'b0);
    check("d_pulse_count_after_reset", pc, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
